gated_hold_bank: RTL and testbench

- Multi-channel, clocked successor to the single-bit enable-gated output pair; each channel is a flop-based, per-channel-mode register, never an inferred latch.
- Per channel: WIDTH-bit data captured while a qualified enable is active; otherwise the output either clears to zero or holds its last value, selected per channel.
- Enable must be high for QUAL consecutive sampled cycles before capture starts, which filters enable glitches.
- Sits at block boundaries where gated data feeds downstream logic.

---
 rtl/gated_hold_bank_if.sv | 39 +++
 rtl/gated_hold_bank.sv | 115 +++++++++++
 tb/tb_gated_hold_bank.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/gated_hold_bank_if.sv
// gated_hold_bank_if
// Groups the per-channel enable/mode/data inputs and the registered
// outputs of gated_hold_bank into one bundle.
//   en     : per-channel enable request
//   mode   : per-channel idle behaviour, 0 = ZERO, 1 = HOLD
//   in     : channel i data at bits [i*WIDTH +: WIDTH]
//   y_out  : registered channel outputs, same packing as in
//   active : channel qualified (counter saturated at QUAL)
//   upd    : one-cycle flag, y_out of that channel changed at the last edge
// master drives the requests, slave (the bank) drives the outputs.
interface gated_hold_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       mode;
    logic [CHANNELS*WIDTH-1:0] in;
    logic [CHANNELS*WIDTH-1:0] y_out;
    logic [CHANNELS-1:0]       active;
    logic [CHANNELS-1:0]       upd;

    modport master (
        output en,
        output mode,
        output in,
        input  y_out,
        input  active,
        input  upd
    );

    modport slave (
        input  en,
        input  mode,
        input  in,
        output y_out,
        output active,
        output upd
    );
endinterface

// File: rtl/gated_hold_bank.sv
// gated_hold_bank
// Bank of independent enable-gated data registers. Each channel captures
// its input only after its enable has been high for QUAL consecutive
// edges, which filters short enable glitches. Outside capture a channel
// either clears to zero (mode=0) or holds its last value (mode=1).
// All outputs come straight from flops; nothing in the bus reaches an
// output combinationally.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, priority over everything
//   bus : gated_hold_bank_if slave (en, mode, in -> y_out, active, upd)
module gated_hold_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int QUAL     = 2
) (
    input  logic             clk,
    input  logic             rst,
    gated_hold_bank_if.slave bus
);
    localparam int CW = $clog2(QUAL + 1);
    localparam logic [CW-1:0] QUAL_C = CW'(QUAL);

    typedef enum logic {
        QUALIFYING = 1'b0,
        ACTIVE     = 1'b1
    } ch_state_e;

    logic [CW-1:0]       cnt_r        [CHANNELS];
    logic [CW-1:0]       cnt_next_s   [CHANNELS];
    ch_state_e           state_r      [CHANNELS];
    ch_state_e           state_next_s [CHANNELS];
    logic [WIDTH-1:0]    y_r          [CHANNELS];
    logic [WIDTH-1:0]    y_next_s     [CHANNELS];
    logic [CHANNELS-1:0] capture_s;
    logic [CHANNELS-1:0] upd_r;
    logic [CHANNELS-1:0] upd_next_s;
    logic [CHANNELS*WIDTH-1:0] y_pack_s;
    logic [CHANNELS-1:0]       active_s;

    // Next-state per channel: saturating qualification counter, capture
    // decision, output value and change flag.
    always_comb begin
        capture_s  = '0;
        upd_next_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_next_s[i]   = '0;
            state_next_s[i] = QUALIFYING;
            y_next_s[i]     = '0;

            if (bus.en[i]) begin
                if (cnt_r[i] == QUAL_C) begin
                    cnt_next_s[i] = cnt_r[i];
                end else begin
                    cnt_next_s[i] = cnt_r[i] + CW'(1);
                end
            end else begin
                cnt_next_s[i] = '0;
            end

            // The saturated next count reaches QUAL exactly when the
            // current count is at least QUAL-1, i.e. this is a capture edge.
            capture_s[i] = bus.en[i] && (cnt_next_s[i] == QUAL_C);

            if (capture_s[i]) begin
                y_next_s[i] = bus.in[i*WIDTH +: WIDTH];
            end else if (bus.mode[i]) begin
                y_next_s[i] = y_r[i];
            end else begin
                y_next_s[i] = '0;
            end

            upd_next_s[i] = (y_next_s[i] != y_r[i]);

            if (cnt_next_s[i] == QUAL_C) begin
                state_next_s[i] = ACTIVE;
            end else begin
                state_next_s[i] = QUALIFYING;
            end
        end
    end

    // Channel state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_r <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i]   <= '0;
                state_r[i] <= QUALIFYING;
                y_r[i]     <= '0;
            end
        end else begin
            upd_r <= upd_next_s;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i]   <= cnt_next_s[i];
                state_r[i] <= state_next_s[i];
                y_r[i]     <= y_next_s[i];
            end
        end
    end

    // Pack the per-channel registers onto the output bus.
    always_comb begin
        y_pack_s = '0;
        active_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            y_pack_s[i*WIDTH +: WIDTH] = y_r[i];
            active_s[i]                = (state_r[i] == ACTIVE);
        end
    end

    assign bus.y_out  = y_pack_s;
    assign bus.active = active_s;
    assign bus.upd    = upd_r;
endmodule

// File: tb/tb_gated_hold_bank.sv
module tb_gated_hold_bank;
    localparam int W  = 8;
    localparam int CH = 4;
    localparam int ND = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CH-1:0]   en_s   = '0;
    logic [CH-1:0]   mode_s = '0;
    logic [CH*W-1:0] in_s   = '0;

    always #5 clk = ~clk;

    gated_hold_bank_if #(.WIDTH(W), .CHANNELS(CH)) bus1 ();
    gated_hold_bank_if #(.WIDTH(W), .CHANNELS(CH)) bus2 ();
    gated_hold_bank_if #(.WIDTH(W), .CHANNELS(CH)) bus3 ();

    assign bus1.en = en_s;  assign bus1.mode = mode_s;  assign bus1.in = in_s;
    assign bus2.en = en_s;  assign bus2.mode = mode_s;  assign bus2.in = in_s;
    assign bus3.en = en_s;  assign bus3.mode = mode_s;  assign bus3.in = in_s;

    gated_hold_bank #(.WIDTH(W), .CHANNELS(CH), .QUAL(1)) u_q1 (.clk(clk), .rst(rst), .bus(bus1));
    gated_hold_bank #(.WIDTH(W), .CHANNELS(CH), .QUAL(2)) u_q2 (.clk(clk), .rst(rst), .bus(bus2));
    gated_hold_bank #(.WIDTH(W), .CHANNELS(CH), .QUAL(3)) u_q3 (.clk(clk), .rst(rst), .bus(bus3));

    typedef struct packed {
        logic [CH*W-1:0] y;
        logic [CH-1:0]   act;
        logic [CH-1:0]   upd;
    } exp_t;
    typedef exp_t [ND-1:0] exp3_t;

    exp_t got [ND];
    assign got[0] = {bus1.y_out, bus1.active, bus1.upd};
    assign got[1] = {bus2.y_out, bus2.active, bus2.upd};
    assign got[2] = {bus3.y_out, bus3.active, bus3.upd};

    exp3_t exp_q [$];
    int checks   = 0;
    int failures = 0;

    // Reference model: run length of consecutive en-high edges per channel
    int          qual_m [ND] = '{1, 2, 3};
    int          run_m  [ND][CH];
    logic [W-1:0] y_m   [ND][CH];

    task automatic step_model();
        exp3_t e;
        logic cap;
        logic [W-1:0] ny;
        e = '0;
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < CH; c++) begin
                if (rst) begin
                    run_m[d][c] = 0;
                    y_m[d][c]   = '0;
                    e[d].upd[c] = 1'b0;
                    e[d].act[c] = 1'b0;
                end else begin
                    // Capture once this edge completes qual_m consecutive en-high edges.
                    cap = en_s[c] && (run_m[d][c] + 1 >= qual_m[d]);
                    if (cap) ny = in_s[c*W +: W];
                    else if (mode_s[c]) ny = y_m[d][c];
                    else ny = '0;
                    e[d].upd[c] = (ny != y_m[d][c]);
                    y_m[d][c]   = ny;
                    run_m[d][c] = en_s[c] ? run_m[d][c] + 1 : 0;
                    e[d].act[c] = (run_m[d][c] >= qual_m[d]);
                end
                e[d].y[c*W +: W] = y_m[d][c];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [CH-1:0] e, input logic [CH-1:0] m,
                         input logic [CH*W-1:0] d);
        @(negedge clk);
        rst    = r;
        en_s   = e;
        mode_s = m;
        in_s   = d;
        step_model();
    endtask

    task automatic check(input string name, input int d, input logic [CH*W-1:0] act_v,
                         input logic [CH*W-1:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s qual=%0d got=%h expected=%h t=%0t", name, qual_m[d], act_v, exp_v, $time);
        end
    endtask

    // Monitor: after each edge compare every DUT against the queued expectation.
    initial begin
        exp3_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int d = 0; d < ND; d++) begin
                    check("y_out",  d, got[d].y, e[d].y);
                    check("active", d, {{(CH*W-CH){1'b0}}, got[d].act}, {{(CH*W-CH){1'b0}}, e[d].act});
                    check("upd",    d, {{(CH*W-CH){1'b0}}, got[d].upd}, {{(CH*W-CH){1'b0}}, e[d].upd});
                end
            end
        end
    end

    initial begin
        logic [CH-1:0]   ren;
        logic [CH-1:0]   rmode;
        logic [CH*W-1:0] rin;
        int guard;
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < CH; c++) begin
                run_m[d][c] = 0;
                y_m[d][c]   = '0;
            end

        // Reset held with everything asserted
        repeat (3) drive(1'b1, 4'hF, 4'h0, 32'hFFFF_FFFF);
        // Release: captures after QUAL edges
        repeat (4) drive(1'b0, 4'hF, 4'h0, 32'hFFFF_FFFF);
        drive(1'b0, 4'h0, 4'h0, 32'h0);

        // Qualification on ch1 with 0x5A
        repeat (5) drive(1'b0, 4'h2, 4'h0, 32'h0000_5A00);
        drive(1'b0, 4'h0, 4'h0, 32'h0);

        // ZERO (ch0) vs HOLD (ch3) with 0xA5, then drop en
        repeat (4) drive(1'b0, 4'h9, 4'h8, 32'hA500_00A5);
        repeat (3) drive(1'b0, 4'h0, 4'h8, 32'h0);

        // Glitch filter on ch2, in both modes
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < 6; k++)
                drive(1'b0, (k % 2 == 0) ? 4'h4 : 4'h0, m[0] ? 4'h4 : 4'h0, 32'h0033_0000);

        // Reset while ch0 is active and capturing
        repeat (4) drive(1'b0, 4'h1, 4'h1, 32'h0000_0011);
        drive(1'b1, 4'h1, 4'h1, 32'h0000_0011);
        repeat (4) drive(1'b0, 4'h1, 4'h1, 32'h0000_0022);
        // HOLD idle, then mode flip clears on the following edge
        repeat (2) drive(1'b0, 4'h0, 4'h1, 32'h0);
        repeat (2) drive(1'b0, 4'h0, 4'h0, 32'h0);

        // Long enable with incrementing data (saturation, no wrap)
        for (int k = 0; k < 300; k++)
            drive(1'b0, 4'hF, 4'h5, {4{k[7:0]}});

        // Random traffic: sticky enables, occasional mode changes and resets
        ren = 4'h0;
        rmode = 4'h0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 3) == 0) ren[c] = ~ren[c];
                if ($urandom_range(0, 9) == 0) rmode[c] = ~rmode[c];
            end
            rin = $urandom();
            if ($urandom_range(0, 7) == 0) rin = in_s;
            drive(($urandom_range(0, 49) == 0), ren, rmode, rin);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
